// File: rtl/pipelined_alu_regfile.sv
// Two-stage ALU with an internal register file: S1 holds the issued operands, S2 holds the result.
// Operands forward from same-edge external writes and from the S1 writeback; the external write wins.
module pipelined_alu_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  In_valid,
  output logic                  In_ready,
  input  logic [2:0]            Opcode,
  input  logic [ADDR_WIDTH-1:0] Src_Addr_1,
  input  logic [ADDR_WIDTH-1:0] Src_Addr_2,
  input  logic [ADDR_WIDTH-1:0] Dest_Addr,
  input  logic                  Wb_enable,
  input  logic                  Carry_In,
  input  logic                  Ext_Write_enable,
  input  logic [ADDR_WIDTH-1:0] Ext_Write_Addr,
  input  logic [DATA_WIDTH-1:0] Ext_Write_data,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [DATA_WIDTH:0]   ALU_Out
);

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

  logic                  vld_p1_q;
  logic [2:0]            op_p1_q;
  logic [DATA_WIDTH-1:0] a_p1_q, b_p1_q;
  logic                  cin_p1_q;
  logic [ADDR_WIDTH-1:0] dst_p1_q;
  logic                  wb_p1_q;

  logic                  vld_p2_q;
  logic [DATA_WIDTH:0]   res_p2_q;

  logic                  adv_p1, adv_p2, issue, wb_fire;
  logic [DATA_WIDTH-1:0] opa_d, opb_d;
  logic [DATA_WIDTH:0]   res_p1;

  // Arithmetic wraps modulo 2^(DATA_WIDTH+1); the MSB carries carry/borrow, logic ops clear it.
  function automatic logic [DATA_WIDTH:0] alu_op(input logic [2:0] op,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b,
                                                 input logic cin);
    logic [DATA_WIDTH:0] ax, bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (op)
      3'b000:  alu_op = ax + bx;
      3'b001:  alu_op = ax + bx + {{DATA_WIDTH{1'b0}}, cin};
      3'b010:  alu_op = ax - bx;
      3'b011:  alu_op = {1'b0, a & b};
      3'b100:  alu_op = {1'b0, a | b};
      3'b101:  alu_op = {1'b0, a ^ b};
      3'b110:  alu_op = {1'b0, ~a};
      default: alu_op = bx;
    endcase
  endfunction

  assign adv_p2   = !vld_p2_q || Out_ready;
  assign adv_p1   = vld_p1_q && adv_p2;
  assign In_ready = Reset_n && (!vld_p1_q || adv_p2);
  assign issue    = In_valid && In_ready;
  assign wb_fire  = adv_p1 && wb_p1_q;
  assign res_p1   = alu_op(op_p1_q, a_p1_q, b_p1_q, cin_p1_q);

  always_comb begin
    opa_d = rf_q[Src_Addr_1];
    opb_d = rf_q[Src_Addr_2];
    if (wb_fire && (dst_p1_q == Src_Addr_1)) opa_d = res_p1[DATA_WIDTH-1:0];
    if (wb_fire && (dst_p1_q == Src_Addr_2)) opb_d = res_p1[DATA_WIDTH-1:0];
    if (Ext_Write_enable && (Ext_Write_Addr == Src_Addr_1)) opa_d = Ext_Write_data;
    if (Ext_Write_enable && (Ext_Write_Addr == Src_Addr_2)) opb_d = Ext_Write_data;
  end

  // Register file: the external write is scheduled last so it wins an address collision.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      if (wb_fire)          rf_q[dst_p1_q]       <= res_p1[DATA_WIDTH-1:0];
      if (Ext_Write_enable) rf_q[Ext_Write_Addr] <= Ext_Write_data;
    end
  end

  // Stage S1: issued operands and control
  always_ff @(posedge Clock) begin
    if (!Reset_n)    vld_p1_q <= 1'b0;
    else if (issue)  vld_p1_q <= 1'b1;
    else if (adv_p1) vld_p1_q <= 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (issue) begin
      op_p1_q  <= Opcode;
      a_p1_q   <= opa_d;
      b_p1_q   <= opb_d;
      cin_p1_q <= Carry_In;
      dst_p1_q <= Dest_Addr;
      wb_p1_q  <= Wb_enable;
    end
  end

  // Stage S2: result register held under backpressure
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (adv_p1) res_p2_q <= res_p1;
    end
  end

  assign Out_valid = vld_p2_q;
  assign ALU_Out   = res_p2_q;

endmodule

// File: tb/tb_pipelined_alu_regfile.sv
// Directed bench for pipelined_alu_regfile: table of single-op vectors plus hand-written
// sequences for reset, forwarding, backpressure, write collisions and mid-flight reset.
module tb_pipelined_alu_regfile;

  logic       Clock = 1'b0;
  logic       Reset_n, In_valid, In_ready, Wb_enable, Carry_In;
  logic [2:0] Opcode, Src_Addr_1, Src_Addr_2, Dest_Addr;
  logic       Ext_Write_enable;
  logic [2:0] Ext_Write_Addr;
  logic [7:0] Ext_Write_data;
  logic       Out_valid, Out_ready;
  logic [8:0] ALU_Out;

  pipelined_alu_regfile #(.DATA_WIDTH(8), .NUM_REGS(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
    .Opcode(Opcode), .Src_Addr_1(Src_Addr_1), .Src_Addr_2(Src_Addr_2),
    .Dest_Addr(Dest_Addr), .Wb_enable(Wb_enable), .Carry_In(Carry_In),
    .Ext_Write_enable(Ext_Write_enable), .Ext_Write_Addr(Ext_Write_Addr),
    .Ext_Write_data(Ext_Write_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .ALU_Out(ALU_Out)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  // A result is taken on the next rising edge when valid and ready are both high here.
  always @(negedge Clock) begin
    if (Out_valid === 1'b1 && Out_ready === 1'b1) got_q.push_back(ALU_Out);
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       cin;
    logic [8:0] exp;
  } vec_t;
  vec_t vec [11];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic wb, input logic cin);
    int n;
    Opcode = op; Src_Addr_1 = a; Src_Addr_2 = b; Dest_Addr = d;
    Wb_enable = wb; Carry_In = cin; In_valid = 1'b1;
    n = 0;
    while (In_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'd0, 32'd1);
    tick();
    In_valid = 1'b0;
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [7:0] d);
    Ext_Write_enable = 1'b1; Ext_Write_Addr = a; Ext_Write_data = d;
    tick();
    Ext_Write_enable = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 50) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_res%0d", name, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // R1=0xF0, R2=0x20
    vec[0]  = '{3'b000, 3'd1, 3'd2, 1'b0, 9'h110};
    vec[1]  = '{3'b010, 3'd2, 3'd1, 1'b0, 9'h130};
    vec[2]  = '{3'b001, 3'd1, 3'd2, 1'b1, 9'h111};
    vec[3]  = '{3'b001, 3'd1, 3'd2, 1'b0, 9'h110};
    vec[4]  = '{3'b010, 3'd1, 3'd2, 1'b0, 9'h0D0};
    vec[5]  = '{3'b011, 3'd1, 3'd2, 1'b0, 9'h020};
    vec[6]  = '{3'b100, 3'd1, 3'd2, 1'b0, 9'h0F0};
    vec[7]  = '{3'b101, 3'd1, 3'd2, 1'b0, 9'h0D0};
    vec[8]  = '{3'b110, 3'd1, 3'd2, 1'b0, 9'h00F};
    vec[9]  = '{3'b111, 3'd1, 3'd2, 1'b0, 9'h020};
    vec[10] = '{3'b000, 3'd1, 3'd1, 1'b0, 9'h1E0};

    Reset_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b1;
    Opcode = 3'd0; Src_Addr_1 = 3'd0; Src_Addr_2 = 3'd0; Dest_Addr = 3'd0;
    Wb_enable = 1'b0; Carry_In = 1'b0;
    Ext_Write_enable = 1'b0; Ext_Write_Addr = 3'd0; Ext_Write_data = 8'd0;

    // Reset, then every register reads zero; first issue on the first edge out of reset
    repeat (2) tick();
    chk("rst_out_valid", Out_valid, 1'b0);
    chk("rst_alu_out", ALU_Out, 9'h000);
    chk("rst_in_ready", In_ready, 1'b0);
    Reset_n = 1'b1;
    got_q.delete();
    #1;
    chk("rel_in_ready", In_ready, 1'b1);
    for (int r = 0; r < 8; r++) begin
      issue(3'b111, r[2:0], r[2:0], 3'd0, 1'b0, 1'b0);
      exp_q.push_back(9'h000);
    end
    drain("pass_zero");

    // Table vectors with latency and Out_valid drop checks
    ext_write(3'd1, 8'hF0);
    ext_write(3'd2, 8'h20);
    for (int i = 0; i < 11; i++) begin
      issue(vec[i].op, vec[i].s1, vec[i].s2, 3'd0, 1'b0, vec[i].cin);
      chk($sformatf("vec%0d_early_valid", i), Out_valid, 1'b0);
      tick();
      chk($sformatf("vec%0d_valid", i), Out_valid, 1'b1);
      chk($sformatf("vec%0d_result", i), ALU_Out, vec[i].exp);
      tick();
      chk($sformatf("vec%0d_drop", i), Out_valid, 1'b0);
    end
    got_q.delete();

    // Back-to-back dependency through S1 writeback forwarding
    ext_write(3'd1, 8'h05);
    ext_write(3'd2, 8'h03);
    issue(3'b000, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    issue(3'b010, 3'd3, 3'd2, 3'd0, 1'b0, 1'b0);
    chk("fwd_first", ALU_Out, 9'h008);
    tick();
    chk("fwd_second_valid", Out_valid, 1'b1);
    chk("fwd_second", ALU_Out, 9'h005);
    repeat (2) tick();
    got_q.delete();
    issue(3'b111, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0);
    exp_q.push_back(9'h008);
    drain("r3_wb");

    // Backpressure: three ops issued while the consumer stalls
    Out_ready = 1'b0;
    issue(3'b000, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0);
    issue(3'b010, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0);
    Opcode = 3'b101; Src_Addr_1 = 3'd1; Src_Addr_2 = 3'd2; Wb_enable = 1'b0;
    In_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_in_ready%0d", c), In_ready, 1'b0);
      chk($sformatf("bp_valid%0d", c), Out_valid, 1'b1);
      chk($sformatf("bp_hold%0d", c), ALU_Out, 9'h008);
    end
    Out_ready = 1'b1;
    #1;
    chk("bp_release_ready", In_ready, 1'b1);
    tick();
    In_valid = 1'b0;
    exp_q.push_back(9'h008);
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h006);
    drain("bp");

    // Same-edge writeback R4=0x11 and external write R4=0xAA with PASS R4 issued
    ext_write(3'd6, 8'h11);
    issue(3'b111, 3'd6, 3'd6, 3'd4, 1'b1, 1'b0);
    Ext_Write_enable = 1'b1; Ext_Write_Addr = 3'd4; Ext_Write_data = 8'hAA;
    issue(3'b111, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0);
    Ext_Write_enable = 1'b0;
    issue(3'b111, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0);
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h0AA);
    exp_q.push_back(9'h0AA);
    drain("collide");

    // Reset while an instruction with writeback is in flight, with a same-edge ext write
    issue(3'b000, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
    Reset_n = 1'b0;
    Ext_Write_enable = 1'b1; Ext_Write_Addr = 3'd7; Ext_Write_data = 8'h55;
    tick();
    Ext_Write_enable = 1'b0;
    chk("midrst_valid", Out_valid, 1'b0);
    chk("midrst_alu_out", ALU_Out, 9'h000);
    chk("midrst_in_ready", In_ready, 1'b0);
    Reset_n = 1'b1;
    tick();
    chk("midrst_no_result", got_q.size(), 0);
    got_q.delete();
    issue(3'b111, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0);
    issue(3'b111, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0);
    issue(3'b111, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h000);
    drain("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
